mem_arbiter: RTL and testbench

- Shares one unified memory port between the Fetch stage (instruction reads) and the Memory stage (loads and stores) of the pipelined MIPS core.
- Sits between the datapath and a memory model whose latency is variable, signalled by ready.
- Arbitrates with data-first priority and a starvation guard for fetch.
- Drives per-stage stall signals consumed by the hazard unit.

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access. Data
// requests win, but only for a bounded burst while a fetch is waiting.
module mem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_D_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          stallF,
    output logic          stallM
);

    localparam int SW = $clog2(MAX_D_BURST + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_BURST);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [SW-1:0] r_dStreak;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [DW-1:0] r_wdata;
    logic          r_ownerD;
    logic [DW-1:0] r_iRdata;
    logic [DW-1:0] r_dRdata;
    logic          w_grantD;
    logic          w_grantI;
    logic          w_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // A data request is refused only when a fetch waits and the burst is used up.
    always_comb begin
        w_next   = r_state;
        w_grantD = 1'b0;
        w_grantI = 1'b0;
        case (r_state)
            IDLE: begin
                if (d_req && (!i_req || (r_dStreak < STREAK_MAX))) begin
                    w_grantD = 1'b1;
                    w_next   = BUSY_D;
                end else if (i_req) begin
                    w_grantI = 1'b1;
                    w_next   = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready)
                    w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_busy = (r_state == BUSY_I) || (r_state == BUSY_D);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dStreak <= '0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_ownerD  <= 1'b0;
            r_iRdata  <= '0;
            r_dRdata  <= '0;
        end else begin
            if (w_grantD) begin
                r_addr    <= d_addr;
                r_we      <= d_we;
                r_wdata   <= d_wdata;
                r_ownerD  <= 1'b1;
                r_dStreak <= i_req ? r_dStreak + 1'b1 : '0;
            end else if (w_grantI) begin
                r_addr    <= i_addr;
                r_we      <= 1'b0;
                r_wdata   <= '0;
                r_ownerD  <= 1'b0;
                r_dStreak <= '0;
            end
            // Stores complete without touching the load-data register.
            if (w_busy && mem_ready) begin
                if (!r_ownerD)
                    r_iRdata <= mem_rdata;
                else if (!r_we)
                    r_dRdata <= mem_rdata;
            end
        end
    end

    assign mem_req   = w_busy;
    assign mem_we    = r_we && (r_state == BUSY_D);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign i_ack     = (r_state == DONE) && !r_ownerD;
    assign d_ack     = (r_state == DONE) && r_ownerD;
    assign i_rdata   = r_iRdata;
    assign d_rdata   = r_dRdata;
    assign stallF    = i_req & ~i_ack;
    assign stallM    = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          stallF;
    logic          stallM;

    int checks   = 0;
    int failures = 0;

    // Model state for the randomized phase
    bit          mBusy, mAck, mOwnD, mWe;
    logic [31:0] mAddr, mWdata, expIr, expDr;
    int          mWait, mStreak;
    bit          iPend, dPend, iDone, dDone, iDrop, dDrop;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_D_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stallF(stallF), .stallM(stallM)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic dw, input logic [31:0] da,
                                 input logic [31:0] dwd, input logic mr, input logic [31:0] md);
        i_req     = ir;
        i_addr    = ia;
        d_req     = dr;
        d_we      = dw;
        d_addr    = da;
        d_wdata   = dwd;
        mem_ready = mr;
        mem_rdata = md;
    endtask

    task automatic runRandom(input int nCycles, input int reqPct);
        bit memDone, nextBusy, nextAck, curIAck, curDAck;
        for (int c = 0; c < nCycles; c++) begin
            nextCycle();
            curIAck = mAck && !mOwnD;
            curDAck = mAck && mOwnD;
            checkOutput("rnd_mem_req", mem_req, mBusy);
            checkOutput("rnd_mem_we", mem_we, mBusy && mWe);
            if (mBusy) begin
                checkOutput("rnd_mem_addr", mem_addr, mAddr);
                checkOutput("rnd_mem_wdata", mem_wdata, mWdata);
            end
            checkOutput("rnd_i_ack", i_ack, curIAck);
            checkOutput("rnd_d_ack", d_ack, curDAck);
            checkOutput("rnd_i_rdata", i_rdata, expIr);
            checkOutput("rnd_d_rdata", d_rdata, expDr);

            // Requesters: retire finished requests, raise new ones, misbehave after grant
            if (iDone) begin iPend = 0; iDrop = 0; iDone = 0; end
            if (dDone) begin dPend = 0; dDrop = 0; dDone = 0; end
            if (curIAck) iDone = 1;
            if (curDAck) dDone = 1;
            if (!iPend && $urandom_range(99) < reqPct) begin
                iPend  = 1;
                i_addr = $urandom;
            end
            if (!dPend && $urandom_range(99) < reqPct) begin
                dPend   = 1;
                d_we    = $urandom_range(1);
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            if (mBusy && !mOwnD) begin
                if ($urandom_range(9) == 0) iDrop = 1;
                if ($urandom_range(3) == 0) i_addr = $urandom;
            end
            if (mBusy && mOwnD) begin
                if ($urandom_range(9) == 0) dDrop = 1;
                if ($urandom_range(3) == 0) begin d_addr = $urandom; d_wdata = $urandom; end
            end
            i_req = iPend && !iDrop;
            d_req = dPend && !dDrop;

            // Memory with a random 0..3 cycle wait per transaction
            memDone   = 0;
            mem_rdata = $urandom;
            if (mBusy) begin
                if (mWait == 0) begin
                    mem_ready = 1;
                    memDone   = 1;
                end else begin
                    mem_ready = 0;
                    mWait--;
                end
            end else begin
                mem_ready = $urandom_range(1);
            end

            nextBusy = mBusy && !memDone;
            nextAck  = memDone;
            if (memDone) begin
                if (!mOwnD) expIr = mem_rdata;
                else if (!mWe) expDr = mem_rdata;
            end
            if (!mBusy && !mAck) begin
                if (d_req && (!i_req || mStreak < MAXB)) begin
                    mOwnD    = 1;
                    mAddr    = d_addr;
                    mWe      = d_we;
                    mWdata   = d_wdata;
                    mStreak  = i_req ? mStreak + 1 : 0;
                    nextBusy = 1;
                    mWait    = $urandom_range(3);
                end else if (i_req) begin
                    mOwnD    = 0;
                    mAddr    = i_addr;
                    mWe      = 0;
                    mWdata   = 0;
                    mStreak  = 0;
                    nextBusy = 1;
                    mWait    = $urandom_range(3);
                end
            end
            mBusy = nextBusy;
            mAck  = nextAck;

            #1;
            checkOutput("rnd_stallF", stallF, i_req && !curIAck);
            checkOutput("rnd_stallM", stallM, d_req && !curDAck);
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_mem_req", mem_req, 0);
        checkOutput("reset_mem_we", mem_we, 0);
        checkOutput("reset_mem_addr", mem_addr, 0);
        checkOutput("reset_mem_wdata", mem_wdata, 0);
        checkOutput("reset_i_ack", i_ack, 0);
        checkOutput("reset_d_ack", d_ack, 0);
        checkOutput("reset_i_rdata", i_rdata, 0);
        checkOutput("reset_d_rdata", d_rdata, 0);
        reset = 1'b0;

        // Single fetch
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("fetch_stallF_idle", stallF, 1);
        nextCycle();
        checkOutput("fetch_mem_req", mem_req, 1);
        checkOutput("fetch_mem_addr", mem_addr, 32'h40);
        checkOutput("fetch_mem_we", mem_we, 0);
        checkOutput("fetch_i_ack_early", i_ack, 0);
        checkOutput("fetch_stallF_busy", stallF, 1);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 1, 32'h8C220004);
        nextCycle();
        checkOutput("fetch_i_ack", i_ack, 1);
        checkOutput("fetch_i_rdata", i_rdata, 32'h8C220004);
        checkOutput("fetch_mem_req_done", mem_req, 0);
        checkOutput("fetch_stallF_ack", stallF, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("fetch_i_ack_once", i_ack, 0);

        // Store with three wait cycles; late input changes must be ignored
        applyStimulus(0, 0, 1, 1, 32'h54, 32'h7, 0, 0);
        nextCycle();
        for (int k = 0; k < 4; k++) begin
            checkOutput("store_mem_req", mem_req, 1);
            checkOutput("store_mem_we", mem_we, 1);
            checkOutput("store_mem_addr", mem_addr, 32'h54);
            checkOutput("store_mem_wdata", mem_wdata, 32'h7);
            checkOutput("store_d_ack_early", d_ack, 0);
            checkOutput("store_stallM", stallM, 1);
            applyStimulus(0, 0, 1, 1, 32'h99, 32'hFF, (k == 3), 32'hDEADBEEF);
            nextCycle();
        end
        checkOutput("store_d_ack", d_ack, 1);
        checkOutput("store_d_rdata", d_rdata, 0);
        checkOutput("store_mem_we_done", mem_we, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("store_d_ack_once", d_ack, 0);

        // Simultaneous requests: data first, then fetch
        applyStimulus(1, 32'h44, 1, 0, 32'h50, 0, 0, 0);
        nextCycle();
        checkOutput("simul_first_addr", mem_addr, 32'h50);
        checkOutput("simul_first_we", mem_we, 0);
        applyStimulus(1, 32'h44, 1, 0, 32'h50, 0, 1, 32'hABCD);
        nextCycle();
        checkOutput("simul_d_ack", d_ack, 1);
        checkOutput("simul_i_ack_no", i_ack, 0);
        checkOutput("simul_d_rdata", d_rdata, 32'hABCD);
        checkOutput("simul_i_rdata_kept", i_rdata, 32'h8C220004);
        applyStimulus(1, 32'h44, 0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("simul_idle_gap", mem_req, 0);
        nextCycle();
        checkOutput("simul_second_req", mem_req, 1);
        checkOutput("simul_second_addr", mem_addr, 32'h44);
        applyStimulus(1, 32'h44, 0, 0, 0, 0, 1, 32'h1234);
        nextCycle();
        checkOutput("simul_i_ack", i_ack, 1);
        checkOutput("simul_i_rdata", i_rdata, 32'h1234);
        checkOutput("simul_d_rdata_kept", d_rdata, 32'hABCD);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();

        // Data requester drops its request after the grant
        applyStimulus(0, 0, 1, 0, 32'h60, 0, 0, 0);
        nextCycle();
        applyStimulus(1, 32'h48, 0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("drop_mem_req", mem_req, 1);
        checkOutput("drop_mem_addr", mem_addr, 32'h60);
        applyStimulus(1, 32'h48, 0, 0, 0, 0, 1, 32'h5555);
        nextCycle();
        checkOutput("drop_d_ack", d_ack, 1);
        checkOutput("drop_d_rdata", d_rdata, 32'h5555);
        applyStimulus(1, 32'h48, 0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("drop_d_ack_once", d_ack, 0);
        nextCycle();
        checkOutput("drop_fetch_req", mem_req, 1);
        checkOutput("drop_fetch_addr", mem_addr, 32'h48);
        applyStimulus(1, 32'h48, 0, 0, 0, 0, 1, 32'h6666);
        nextCycle();
        checkOutput("drop_i_ack", i_ack, 1);
        checkOutput("drop_i_rdata", i_rdata, 32'h6666);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();

        // Reset in the middle of a store
        applyStimulus(0, 0, 1, 1, 32'h70, 32'h11, 0, 0);
        nextCycle();
        checkOutput("rst_mid_mem_req_before", mem_req, 1);
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_mem_req", mem_req, 0);
        checkOutput("rst_mid_mem_we", mem_we, 0);
        checkOutput("rst_mid_mem_addr", mem_addr, 0);
        checkOutput("rst_mid_mem_wdata", mem_wdata, 0);
        checkOutput("rst_mid_i_rdata", i_rdata, 0);
        checkOutput("rst_mid_d_rdata", d_rdata, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hFFFF);
        nextCycle();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            checkOutput("rst_mid_no_d_ack", d_ack, 0);
            checkOutput("rst_mid_no_mem_req", mem_req, 0);
        end

        // Randomized traffic from a clean reset state
        mBusy = 0; mAck = 0; mOwnD = 0; mWe = 0; mAddr = 0; mWdata = 0;
        expIr = 0; expDr = 0; mWait = 0; mStreak = 0;
        iPend = 0; dPend = 0; iDone = 0; dDone = 0; iDrop = 0; dDrop = 0;
        runRandom(1500, 40);
        runRandom(600, 100);
        runRandom(600, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
